// File: rtl/msj_angle_tracker_pkg.sv
// Shared types and defaults for the MSJ per-sensor angle tracker.
// Contents: the default raw angle width, the per-sensor state record, the
// unwrap result record, and a helper that builds the post-reset sensor state.
package msj_angle_tracker_pkg;

  localparam int DEFAULT_ANGLE_BITS = 12;

  // Per-sensor tracking state; prev holds the raw angle zero-extended.
  typedef struct packed {
    logic        [31:0] prev;
    logic signed [31:0] rev;
    logic signed [31:0] absolute;
    logic signed [31:0] offset;
    logic signed [31:0] acc;
    logic        [31:0] count;
    logic               first;
  } sensor_state_t;

  // Unwrapped delta plus the revolution step (-1, 0, +1) it implies.
  typedef struct packed {
    logic signed [31:0] delta;
    logic signed [1:0]  rev_step;
  } unwrap_result_t;

  function automatic sensor_state_t reset_state();
    sensor_state_t s;
    s       = '0;
    s.first = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/msj_angle_unwrap.sv
// Combinational single-turn unwrap: delta between the previous and the new raw
// angle folded into the half-open range [-2^(W-1), 2^(W-1)-1], with rev step.
// Ports: prev_i / angle_i raw unsigned angles in, result_o delta + rev_step out.
module msj_angle_unwrap
  import msj_angle_tracker_pkg::*;
#(
  parameter int ANGLE_BITS = DEFAULT_ANGLE_BITS
) (
  input  logic [ANGLE_BITS-1:0] prev_i,
  input  logic [ANGLE_BITS-1:0] angle_i,
  output unwrap_result_t        result_o
);

  localparam logic signed [31:0] HALF = 32'sd1 <<< (ANGLE_BITS - 1);
  localparam logic signed [31:0] FULL = 32'sd1 <<< ANGLE_BITS;

  logic signed [31:0] d;

  always_comb begin
    // Both operands are zero-extended, so d spans the signed W+1-bit range.
    d                 = $signed(32'(angle_i)) - $signed(32'(prev_i));
    result_o.delta    = d;
    result_o.rev_step = 2'sd0;
    if (d > HALF - 32'sd1) begin
      // Large forward jump is really a backward crossing of zero.
      result_o.delta    = d - FULL;
      result_o.rev_step = -2'sd1;
    end else if (d < -HALF) begin
      result_o.delta    = d + FULL;
      result_o.rev_step = 2'sd1;
    end
  end

endmodule

// File: rtl/msj_angle_tracker.sv
// Multi-turn angle tracker: unwraps raw per-sensor angles, keeps revolution
// counters, a zeroing offset, a windowed velocity and pulses cycle[k] per commit.
// Ports: clock/reset (sync, active high); sample_* raw input; zero_offset level;
// per-sensor angle/absolute/offset/relative/velocity/rev/error_count; cycle.
// Optional: MSJ_ANGLE_TRACKER_ERROR_COUNT_EN builds the rejected-frame counters.
module msj_angle_tracker
  import msj_angle_tracker_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS  = 6,
  parameter int ANGLE_BITS         = DEFAULT_ANGLE_BITS,
  parameter int SAMPLES_TO_AVERAGE = 256
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [7:0]                   sample_sensor,
  input  logic [ANGLE_BITS-1:0]        sample_angle,
  input  logic                         sample_error,
  input  logic                         zero_offset,
  output logic [31:0]                  sensor_angle             [NUMBER_OF_SENSORS],
  output logic signed [31:0]           sensor_angle_absolute    [NUMBER_OF_SENSORS],
  output logic signed [31:0]           sensor_angle_offset      [NUMBER_OF_SENSORS],
  output logic signed [31:0]           sensor_angle_relative    [NUMBER_OF_SENSORS],
  output logic signed [31:0]           sensor_angle_velocity    [NUMBER_OF_SENSORS],
  output logic signed [31:0]           sensor_revolution_counter[NUMBER_OF_SENSORS],
  output logic [15:0]                  sensor_error_count       [NUMBER_OF_SENSORS],
  output logic [NUMBER_OF_SENSORS-1:0] cycle
);

  localparam int AVG_SHIFT = $clog2(SAMPLES_TO_AVERAGE);

  // S0 input register; out-of-range indices are dropped here.
  logic                  s0_vld_q;
  logic [7:0]            s0_sensor_q;
  logic [ANGLE_BITS-1:0] s0_angle_q;
  logic                  s0_err_q;

  // Zero-offset edge detect: two-stage so the offset lands 2 clocks after the edge.
  logic zero_s0_q, zero_s1_q, zero_rise;

  sensor_state_t             st_q  [NUMBER_OF_SENSORS];
  sensor_state_t             st_d  [NUMBER_OF_SENSORS];
  logic signed [31:0]        rel_q [NUMBER_OF_SENSORS];
  logic signed [31:0]        rel_d [NUMBER_OF_SENSORS];
  logic signed [31:0]        vel_q [NUMBER_OF_SENSORS];
  logic signed [31:0]        vel_d [NUMBER_OF_SENSORS];
  logic [NUMBER_OF_SENSORS-1:0] cycle_q, cycle_d;

  // S1: state of the addressed sensor. State is written at the end of S1, so a
  // back-to-back sample for the same sensor sees the freshly committed values.
  logic [ANGLE_BITS-1:0] sel_prev;
  logic signed [31:0]    sel_rev, sel_acc, sel_offset;
  logic [31:0]           sel_count;
  logic                  sel_first;

  unwrap_result_t        uw;
  logic                  commit, win_done;
  logic signed [31:0]    rev_n, abs_n, sum_n, off_n;

  msj_angle_unwrap #(.ANGLE_BITS(ANGLE_BITS)) u_unwrap (
    .prev_i   (sel_prev),
    .angle_i  (s0_angle_q),
    .result_o (uw)
  );

  assign zero_rise = zero_s0_q & ~zero_s1_q;
  assign commit    = s0_vld_q & ~s0_err_q;

  always_comb begin
    sel_prev   = '0;
    sel_rev    = '0;
    sel_acc    = '0;
    sel_offset = '0;
    sel_count  = '0;
    sel_first  = 1'b0;
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
      if (s0_sensor_q == 8'(i)) begin
        sel_prev   = st_q[i].prev[ANGLE_BITS-1:0];
        sel_rev    = st_q[i].rev;
        sel_acc    = st_q[i].acc;
        sel_offset = st_q[i].offset;
        sel_count  = st_q[i].count;
        sel_first  = st_q[i].first;
      end
    end

    // The first sample only seeds prev; rev keeps its reset value.
    rev_n    = sel_first ? sel_rev : sel_rev + 32'(uw.rev_step);
    abs_n    = (rev_n <<< ANGLE_BITS) + $signed(32'(s0_angle_q));
    sum_n    = sel_acc + uw.delta;
    win_done = (sel_count == 32'(SAMPLES_TO_AVERAGE - 1));
    // A zero event coinciding with the commit captures the new absolute value.
    off_n    = zero_rise ? abs_n : sel_offset;
  end

  always_comb begin
    cycle_d = '0;
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
      st_d[i]  = st_q[i];
      rel_d[i] = rel_q[i];
      vel_d[i] = vel_q[i];
      if (commit && (s0_sensor_q == 8'(i))) begin
        st_d[i].prev     = 32'(s0_angle_q);
        st_d[i].rev      = rev_n;
        st_d[i].absolute = abs_n;
        st_d[i].offset   = off_n;
        st_d[i].first    = 1'b0;
        rel_d[i]         = abs_n - off_n;
        cycle_d[i]       = 1'b1;
        if (!sel_first) begin
          if (win_done) begin
            vel_d[i]      = sum_n >>> AVG_SHIFT;
            st_d[i].acc   = '0;
            st_d[i].count = '0;
          end else begin
            st_d[i].acc   = sum_n;
            st_d[i].count = sel_count + 32'd1;
          end
        end
      end else if (zero_rise) begin
        st_d[i].offset = st_q[i].absolute;
        rel_d[i]       = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_vld_q    <= 1'b0;
      s0_sensor_q <= '0;
      s0_angle_q  <= '0;
      s0_err_q    <= 1'b0;
      zero_s0_q   <= 1'b0;
      zero_s1_q   <= 1'b0;
      cycle_q     <= '0;
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        st_q[i]  <= reset_state();
        rel_q[i] <= '0;
        vel_q[i] <= '0;
      end
    end else begin
      s0_vld_q    <= sample_valid && (sample_sensor < 8'(NUMBER_OF_SENSORS));
      s0_sensor_q <= sample_sensor;
      s0_angle_q  <= sample_angle;
      s0_err_q    <= sample_error;
      zero_s0_q   <= zero_offset;
      zero_s1_q   <= zero_s0_q;
      cycle_q     <= cycle_d;
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        st_q[i]  <= st_d[i];
        rel_q[i] <= rel_d[i];
        vel_q[i] <= vel_d[i];
      end
    end
  end

`ifdef MSJ_ANGLE_TRACKER_ERROR_COUNT_EN
  logic [15:0] err_q [NUMBER_OF_SENSORS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) err_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
        if (s0_vld_q && s0_err_q && (s0_sensor_q == 8'(i)) && (err_q[i] != 16'hFFFF))
          err_q[i] <= err_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) sensor_error_count[i] = err_q[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) sensor_error_count[i] = '0;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
      sensor_angle[i]              = st_q[i].prev;
      sensor_angle_absolute[i]     = st_q[i].absolute;
      sensor_angle_offset[i]       = st_q[i].offset;
      sensor_angle_relative[i]     = rel_q[i];
      sensor_angle_velocity[i]     = vel_q[i];
      sensor_revolution_counter[i] = st_q[i].rev;
    end
  end

  assign cycle = cycle_q;

endmodule

// File: tb/tb_msj_angle_tracker.sv
// Directed self-checking bench for msj_angle_tracker (velocity window of 4).
// Ports: none; drives the DUT on negedges, samples 1 time unit after posedges.
module tb_msj_angle_tracker;

  localparam int N  = 6;
  localparam int AB = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [7:0]        sample_sensor;
  logic [AB-1:0]     sample_angle;
  logic              sample_error;
  logic              zero_offset;
  logic [31:0]        sensor_angle             [N];
  logic signed [31:0] sensor_angle_absolute    [N];
  logic signed [31:0] sensor_angle_offset      [N];
  logic signed [31:0] sensor_angle_relative    [N];
  logic signed [31:0] sensor_angle_velocity    [N];
  logic signed [31:0] sensor_revolution_counter[N];
  logic [15:0]        sensor_error_count       [N];
  logic [N-1:0]       cycle;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MSJ_ANGLE_TRACKER_ERROR_COUNT_EN
  localparam int ERR_ONE = 1;
  localparam int ERR_SAT = 65535;
`else
  localparam int ERR_ONE = 0;
  localparam int ERR_SAT = 0;
`endif

  msj_angle_tracker #(
    .NUMBER_OF_SENSORS (N),
    .ANGLE_BITS        (AB),
    .SAMPLES_TO_AVERAGE(4)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .sample_valid             (sample_valid),
    .sample_sensor            (sample_sensor),
    .sample_angle             (sample_angle),
    .sample_error             (sample_error),
    .zero_offset              (zero_offset),
    .sensor_angle             (sensor_angle),
    .sensor_angle_absolute    (sensor_angle_absolute),
    .sensor_angle_offset      (sensor_angle_offset),
    .sensor_angle_relative    (sensor_angle_relative),
    .sensor_angle_velocity    (sensor_angle_velocity),
    .sensor_revolution_counter(sensor_revolution_counter),
    .sensor_error_count       (sensor_error_count),
    .cycle                    (cycle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] s, input int a, input logic e);
    @(negedge clock);
    sample_valid  = 1'b1;
    sample_sensor = s;
    sample_angle  = AB'(a);
    sample_error  = e;
  endtask

  task automatic idle();
    @(negedge clock);
    sample_valid = 1'b0;
    sample_error = 1'b0;
  endtask

  // One sample, then wait until just after the commit edge.
  task automatic send(input logic [7:0] s, input int a, input logic e);
    put(s, a, e);
    idle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic saw4;
    reset         = 1'b1;
    sample_valid  = 1'b0;
    sample_sensor = '0;
    sample_angle  = '0;
    sample_error  = 1'b0;
    zero_offset   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_abs0",   sensor_angle_absolute[0], 0);
    chk("rst_cycle",  32'(cycle), 0);
    chk("rst_vel0",   sensor_angle_velocity[0], 0);
    chk("rst_err0",   32'(sensor_error_count[0]), 0);
    @(negedge clock);
    reset = 1'b0;

    // First sample after reset
    send(8'd0, 100, 1'b0);
    chk("first_abs0",   sensor_angle_absolute[0], 100);
    chk("first_rev0",   sensor_revolution_counter[0], 0);
    chk("first_ang0",   $signed(sensor_angle[0]), 100);
    chk("first_cycle",  32'(cycle), 32'h1);
    chk("first_vel0",   sensor_angle_velocity[0], 0);
    @(posedge clock);
    #1;
    chk("first_cycle_gone", 32'(cycle), 0);

    // Forward wrap on sensor 1, reverse wrap on sensor 5
    send(8'd1, 4090, 1'b0);
    send(8'd1, 5, 1'b0);
    chk("fwd_rev1",   sensor_revolution_counter[1], 1);
    chk("fwd_abs1",   sensor_angle_absolute[1], 4101);
    chk("fwd_rel1",   sensor_angle_relative[1], 4101);
    send(8'd5, 5, 1'b0);
    send(8'd5, 4090, 1'b0);
    chk("rev_rev5",   sensor_revolution_counter[5], -1);
    chk("rev_abs5",   sensor_angle_absolute[5], -6);
    chk("rev_cycle",  32'(cycle), 32'h20);

    // Velocity window with errored / out-of-range samples interleaved
    send(8'd2, 0, 1'b0);
    send(8'd2, 10, 1'b0);
    send(8'd2, 999, 1'b1);
    chk("err_cycle",  32'(cycle), 0);
    chk("err_abs2",   sensor_angle_absolute[2], 10);
    chk("err_cnt2",   32'(sensor_error_count[2]), ERR_ONE);
    send(8'd7, 999, 1'b0);
    chk("oor_cycle",  32'(cycle), 0);
    send(8'd2, 20, 1'b0);
    send(8'd2, 30, 1'b0);
    chk("vel_pending", sensor_angle_velocity[2], 0);
    send(8'd2, 40, 1'b0);
    chk("vel2",       sensor_angle_velocity[2], 10);
    chk("vel_abs2",   sensor_angle_absolute[2], 40);

    // Same-sensor burst on consecutive clocks
    put(8'd3, 4094, 1'b0);
    put(8'd3, 2, 1'b0);
    put(8'd3, 10, 1'b0);
    idle();
    @(posedge clock);
    #1;
    chk("burst_rev3",  sensor_revolution_counter[3], 1);
    chk("burst_abs3",  sensor_angle_absolute[3], 4106);
    chk("burst_cycle", 32'(cycle), 32'h8);

    // Zero edge coinciding with a sensor 0 commit
    send(8'd0, 500, 1'b0);
    chk("pre_zero_abs0", sensor_angle_absolute[0], 500);
    @(negedge clock);
    sample_valid  = 1'b1;
    sample_sensor = 8'd0;
    sample_angle  = AB'(520);
    sample_error  = 1'b0;
    zero_offset   = 1'b1;
    idle();
    @(posedge clock);
    #1;
    chk("zero_off0",  sensor_angle_offset[0], 520);
    chk("zero_rel0",  sensor_angle_relative[0], 0);
    chk("zero_off1",  sensor_angle_offset[1], 4101);
    chk("zero_rel1",  sensor_angle_relative[1], 0);
    send(8'd0, 530, 1'b0);
    chk("post_rel0",  sensor_angle_relative[0], 10);
    chk("post_off0",  sensor_angle_offset[0], 520);

    // Error counter saturation on sensor 4
    saw4 = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      put(8'd4, n, 1'b1);
      if (cycle[4]) saw4 = 1'b1;
    end
    idle();
    @(posedge clock);
    #1;
    if (cycle[4]) saw4 = 1'b1;
    chk("sat_cnt4",   32'(sensor_error_count[4]), ERR_SAT);
    chk("sat_nocyc4", 32'(saw4), 0);

    // Reset with a sample in flight
    put(8'd0, 900, 1'b0);
    @(negedge clock);
    sample_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_abs0",  sensor_angle_absolute[0], 0);
    chk("mid_rst_off0",  sensor_angle_offset[0], 0);
    chk("mid_rst_cycle", 32'(cycle), 0);
    chk("mid_rst_err4",  32'(sensor_error_count[4]), 0);
    chk("mid_rst_vel2",  sensor_angle_velocity[2], 0);
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
